// File: rtl/hex_editor_pkg.sv
// hex_editor_pkg: shared types and constants for the hex editor.
//   state_t   : editor FSM state (IDLE / EDIT)
//   BTN_*     : bit index of each button in the debounced press vector
//   PRIO      : button indices, highest-priority action first
//   cnt_w     : counter width for a modulus, never below 1 bit
package hex_editor_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EDIT = 1'b1
   } state_t;

   localparam int BTN_MODE  = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_RIGHT = 2;
   localparam int BTN_UP    = 3;
   localparam int BTN_DOWN  = 4;
   localparam int BTN_PT    = 5;
   localparam int NUM_BTN   = 6;

   // When several presses land in one cycle only the first listed one acts.
   localparam int PRIO [NUM_BTN] = '{BTN_MODE, BTN_UP, BTN_DOWN,
                                     BTN_LEFT, BTN_RIGHT, BTN_PT};

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises one raw push-button, debounces it and emits a
// one-cycle pulse on each accepted press (release produces nothing).
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   raw   : asynchronous button input
//   level : debounced button level
//   press : registered 1-cycle pulse on a debounced rising edge
module btn_debounce
   import hex_editor_pkg::*;
#(
   parameter int CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = cnt_w(CYCLES);

   logic          s1, s2;
   logic          level_q;
   logic [CW-1:0] cnt;

   // cnt counts consecutive synced samples that disagree with the accepted
   // level; any agreeing sample (i.e. a bounce back) restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         s1      <= raw;
         s2      <= s1;
         level_q <= level;
         press   <= level & ~level_q;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(CYCLES - 1)) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hex_editor.sv
// hex_editor: turns six raw buttons into edits of a 4-digit hex value with
// per-digit decimal points; the selected digit blinks while editing.
//   clk, rst                : clock, asynchronous active-low reset
//   btn_mode/left/right/up/down/pt : raw push-buttons
//   hexs      : 4 nibbles, nibble 3 is the leftmost digit
//   points    : decimal point per digit, 1 = lit
//   LEs       : blank per digit, 1 = blanked (blink of selected digit)
//   edit_mode : 1 while editing
//   sel       : selected digit index
module hex_editor
   import hex_editor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLINK_CYCLES    = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_mode,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_pt,
   output logic [15:0] hexs,
   output logic [3:0]  points,
   output logic [3:0]  LEs,
   output logic        edit_mode,
   output logic [1:0]  sel
);

   localparam int BW = cnt_w(BLINK_CYCLES);

   logic [NUM_BTN-1:0] raw;
   logic [NUM_BTN-1:0] press;
   // Edits act only on press pulses; the held levels are not needed here.
   logic [NUM_BTN-1:0] lvl_unused;

   assign raw[BTN_MODE]  = btn_mode;
   assign raw[BTN_LEFT]  = btn_left;
   assign raw[BTN_RIGHT] = btn_right;
   assign raw[BTN_UP]    = btn_up;
   assign raw[BTN_DOWN]  = btn_down;
   assign raw[BTN_PT]    = btn_pt;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw[g]),
         .level (lvl_unused[g]),
         .press (press[g])
      );
   end

   state_t        state, state_n;
   logic [15:0]   hexs_n;
   logic [3:0]    points_n, les_n;
   logic [1:0]    sel_n;
   logic [BW-1:0] bcnt, bcnt_n;
   logic          phase, phase_n;
   logic [NUM_BTN-1:0] act;
   logic [3:0]    nib;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         hexs   <= '0;
         points <= '0;
         LEs    <= '0;
         sel    <= '0;
         bcnt   <= '0;
         phase  <= 1'b0;
      end else begin
         state  <= state_n;
         hexs   <= hexs_n;
         points <= points_n;
         LEs    <= les_n;
         sel    <= sel_n;
         bcnt   <= bcnt_n;
         phase  <= phase_n;
      end
   end

   assign edit_mode = (state == EDIT);

   always_comb begin
      state_n  = state;
      hexs_n   = hexs;
      points_n = points;
      sel_n    = sel;
      bcnt_n   = bcnt;
      phase_n  = phase;
      act      = '0;
      nib      = hexs[{sel, 2'b00} +: 4];

      // One-hot of the single winning press this cycle.
      for (int i = 0; i < NUM_BTN; i++) begin
         if (press[PRIO[i]] && (act == '0)) act[PRIO[i]] = 1'b1;
      end

      case (state)
         IDLE: begin
            bcnt_n  = '0;
            phase_n = 1'b0;
            if (act[BTN_MODE]) state_n = EDIT;
         end
         EDIT: begin
            if (bcnt == BW'(BLINK_CYCLES - 1)) begin
               bcnt_n  = '0;
               phase_n = ~phase;
            end else begin
               bcnt_n = bcnt + 1'b1;
            end
            if (act[BTN_MODE]) begin
               state_n = IDLE;
               bcnt_n  = '0;
               phase_n = 1'b0;
            end else if (act[BTN_UP]) begin
               hexs_n[{sel, 2'b00} +: 4] = nib + 4'd1;
            end else if (act[BTN_DOWN]) begin
               hexs_n[{sel, 2'b00} +: 4] = nib - 4'd1;
            end else if (act[BTN_LEFT]) begin
               sel_n = sel + 2'd1;
            end else if (act[BTN_RIGHT]) begin
               sel_n = sel - 2'd1;
            end else if (act[BTN_PT]) begin
               points_n[sel] = ~points[sel];
            end
         end
         default: state_n = IDLE;
      endcase

      // Built from next-state values so the blink follows a sel move in the
      // same cycle, without restarting the phase.
      les_n = (state_n == EDIT) ? (4'(phase_n) << sel_n) : 4'b0000;
   end

endmodule

// File: tb/tb_hex_editor.sv
// tb_hex_editor: directed, table-driven bench for hex_editor with short
// debounce/blink periods (4 / 8 cycles).
module tb_hex_editor;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_mode, btn_left, btn_right, btn_up, btn_down, btn_pt;
   logic [15:0] hexs;
   logic [3:0]  points, LEs;
   logic        edit_mode;
   logic [1:0]  sel;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] M = 6'b000001;
   localparam logic [5:0] L = 6'b000010;
   localparam logic [5:0] R = 6'b000100;
   localparam logic [5:0] U = 6'b001000;
   localparam logic [5:0] D = 6'b010000;
   localparam logic [5:0] P = 6'b100000;

   typedef struct {
      logic [5:0]  btn;
      logic [15:0] hexs;
      logic [3:0]  points;
      logic [1:0]  sel;
      logic        edit;
   } vec_t;

   vec_t vt [20];

   hex_editor #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_pt    (btn_pt),
      .hexs      (hexs),
      .points    (points),
      .LEs       (LEs),
      .edit_mode (edit_mode),
      .sel       (sel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btns(input logic [5:0] v);
      btn_mode  = v[0];
      btn_left  = v[1];
      btn_right = v[2];
      btn_up    = v[3];
      btn_down  = v[4];
      btn_pt    = v[5];
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask

   // Hold for 10 cycles, then release and let the release settle.
   task automatic press(input logic [5:0] v);
      set_btns(v);
      repeat (10) tick();
      set_btns(6'b0);
      repeat (10) tick();
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_hexs"}, hexs, 16'h0000);
      chk({nm, "_points"}, 16'(points), 16'h0);
      chk({nm, "_LEs"}, 16'(LEs), 16'h0);
      chk({nm, "_edit"}, 16'(edit_mode), 16'h0);
      chk({nm, "_sel"}, 16'(sel), 16'h0);
   endtask

   initial begin
      vt[0]  = '{U, 16'h0002, 4'b0000, 2'd0, 1'b1};
      vt[1]  = '{U, 16'h0003, 4'b0000, 2'd0, 1'b1};
      vt[2]  = '{D, 16'h0002, 4'b0000, 2'd0, 1'b1};
      vt[3]  = '{D, 16'h0001, 4'b0000, 2'd0, 1'b1};
      vt[4]  = '{D, 16'h0000, 4'b0000, 2'd0, 1'b1};
      vt[5]  = '{D, 16'h000F, 4'b0000, 2'd0, 1'b1};
      vt[6]  = '{L, 16'h000F, 4'b0000, 2'd1, 1'b1};
      vt[7]  = '{L, 16'h000F, 4'b0000, 2'd2, 1'b1};
      vt[8]  = '{U, 16'h010F, 4'b0000, 2'd2, 1'b1};
      vt[9]  = '{P, 16'h010F, 4'b0100, 2'd2, 1'b1};
      vt[10] = '{R, 16'h010F, 4'b0100, 2'd1, 1'b1};
      vt[11] = '{R, 16'h010F, 4'b0100, 2'd0, 1'b1};
      vt[12] = '{R, 16'h010F, 4'b0100, 2'd3, 1'b1};
      vt[13] = '{U, 16'h110F, 4'b0100, 2'd3, 1'b1};
      vt[14] = '{L, 16'h110F, 4'b0100, 2'd0, 1'b1};
      vt[15] = '{M, 16'h110F, 4'b0100, 2'd0, 1'b0};
      vt[16] = '{U, 16'h110F, 4'b0100, 2'd0, 1'b0};
      vt[17] = '{P, 16'h110F, 4'b0100, 2'd0, 1'b0};
      vt[18] = '{L, 16'h110F, 4'b0100, 2'd0, 1'b0};
      vt[19] = '{M, 16'h110F, 4'b0100, 2'd0, 1'b1};

      rst = 1'b0;
      set_btns(6'b0);
      repeat (2) tick();
      chk_reset("reset");
      rst = 1'b1;
      repeat (2) tick();

      // Press latency: raw rises before edge k, update visible after k+7.
      set_btns(M);
      repeat (7) tick();
      chk("lat_mode_early", 16'(edit_mode), 16'h0);
      tick();
      chk("lat_mode_on", 16'(edit_mode), 16'h1);
      chk("lat_mode_LEs", 16'(LEs), 16'h0);
      set_btns(6'b0);
      repeat (10) tick();

      set_btns(U);
      repeat (7) tick();
      chk("lat_up_early", hexs, 16'h0000);
      tick();
      chk("lat_up_on", hexs, 16'h0001);
      set_btns(6'b0);
      repeat (10) tick();

      for (int i = 0; i < 20; i++) begin
         press(vt[i].btn);
         chk($sformatf("vec%0d_hexs", i), hexs, vt[i].hexs);
         chk($sformatf("vec%0d_points", i), 16'(points), 16'(vt[i].points));
         chk($sformatf("vec%0d_sel", i), 16'(sel), 16'(vt[i].sel));
         chk($sformatf("vec%0d_edit", i), 16'(edit_mode), 16'(vt[i].edit));
      end

      // Bounce: 2-cycle runs never reach 4 stable samples.
      for (int i = 0; i < 5; i++) begin
         set_btns(U);
         repeat (2) tick();
         set_btns(6'b0);
         repeat (2) tick();
      end
      repeat (15) tick();
      chk("bounce_hexs", hexs, 16'h110F);

      // Blink: leave EDIT, re-enter on a known edge, then count phases.
      press(M);
      chk("idle_LEs", 16'(LEs), 16'h0);
      chk("idle_edit", 16'(edit_mode), 16'h0);
      set_btns(M);
      repeat (8) tick();
      chk("blink_enter_edit", 16'(edit_mode), 16'h1);
      chk("blink_enter_LEs", 16'(LEs), 16'h0);
      set_btns(6'b0);
      for (int n = 1; n <= 40; n++) begin
         tick();
         chk($sformatf("blink_n%0d", n), 16'(LEs), ((n / 8) % 2 == 1) ? 16'h1 : 16'h0);
      end
      set_btns(R);
      for (int n = 41; n <= 64; n++) begin
         int s;
         logic [3:0] e;
         tick();
         s = (n >= 48) ? 3 : 0;
         e = ((n / 8) % 2 == 1) ? (4'b0001 << s) : 4'b0000;
         chk($sformatf("move_sel_n%0d", n), 16'(sel), 16'(s));
         chk($sformatf("move_LEs_n%0d", n), 16'(LEs), 16'(e));
         if (n == 50) set_btns(6'b0);
      end
      repeat (10) tick();

      // Simultaneous presses: up beats pt, mode beats up.
      press(U | P);
      chk("simul_up_hexs", hexs, 16'h210F);
      chk("simul_up_points", 16'(points), 16'h4);
      press(M | U);
      chk("simul_mode_edit", 16'(edit_mode), 16'h0);
      chk("simul_mode_hexs", hexs, 16'h210F);
      press(M);
      chk("simul_back_edit", 16'(edit_mode), 16'h1);

      // Reset mid-debounce, down held through release: ignored in IDLE.
      set_btns(D);
      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk_reset("async_rst");
      repeat (2) tick();
      rst = 1'b1;
      repeat (20) tick();
      chk("held_down_hexs", hexs, 16'h0000);
      chk("held_down_edit", 16'(edit_mode), 16'h0);
      set_btns(6'b0);
      repeat (10) tick();

      // Mode held through reset release: exactly one toggle.
      set_btns(M);
      tick();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      repeat (20) tick();
      chk("held_mode_edit", 16'(edit_mode), 16'h1);
      set_btns(6'b0);
      repeat (10) tick();
      press(D);
      chk("post_rst_down", hexs, 16'h000F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
